// File: rtl/tetris_vga_renderer.sv
// tetris_vga_renderer: 640x480@60 VGA timing plus a bordered cell-grid view of the
// tetris playfield, snapshotted once per frame in vertical blank.
module tetris_vga_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CELL     = 16,
    parameter int GRID_X0  = 240,
    parameter int GRID_Y0  = 80,
    parameter int BORDER   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [19:0][9:0] display_array,
    input  logic             gameover,
    output logic             hsync,
    output logic             vsync,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue,
    output logic             frame_start
);
    localparam int CS = $clog2(CELL);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HA = 10'(H_ACTIVE);
    localparam logic [9:0] VA = 10'(V_ACTIVE);
    localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam int GX1 = GRID_X0 + 10 * CELL;
    localparam int GY1 = GRID_Y0 + 20 * CELL;

    logic [9:0]   h_q, h_d, v_q, v_d;
    logic [199:0] grid_q;
    logic         go_q;
    logic [9:0]   p_h_q, p_v_q;
    logic         p_act_q, p_hs_q, p_vs_q, p_fs_q;
    logic         hs_q, vs_q, fs_q;
    logic [11:0]  rgb_q, rgb_d;
    logic [9:0]   dx, dy;
    logic [4:0]   srow;
    logic [3:0]   col;
    logic [7:0]   idx;
    logic         in_grid, in_band, grid_line;

    always_comb begin
        h_d = (h_q == H_LAST) ? '0 : h_q + 10'd1;
        v_d = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end

    // Offsets are only meaningful once in_grid holds, so the subtraction never wraps in use.
    always_comb begin
        in_grid = int'(p_h_q) >= GRID_X0 && int'(p_h_q) < GX1 &&
                  int'(p_v_q) >= GRID_Y0 && int'(p_v_q) < GY1;
        in_band = int'(p_h_q) >= GRID_X0 - BORDER && int'(p_h_q) < GX1 + BORDER &&
                  int'(p_v_q) >= GRID_Y0 - BORDER && int'(p_v_q) < GY1 + BORDER;
        dx = p_h_q - 10'(GRID_X0);
        dy = p_v_q - 10'(GRID_Y0);
        col = 4'(dx >> CS);
        srow = 5'(dy >> CS);
        idx = 8'((5'd19 - srow) * 8'd10) + {4'd0, col};
        grid_line = dx[CS-1:0] == '0 || dy[CS-1:0] == '0;
        rgb_d = !p_act_q ? 12'h000 :
                in_grid ? (grid_line ? 12'h222 : grid_q[idx] ? 12'hFFF : 12'h000) :
                in_band ? (go_q ? 12'hF00 : 12'h888) : 12'h000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q     <= '0;
            v_q     <= '0;
            grid_q  <= '0;
            go_q    <= 1'b0;
            p_h_q   <= '0;
            p_v_q   <= '0;
            p_act_q <= 1'b0;
            p_hs_q  <= 1'b1;
            p_vs_q  <= 1'b1;
            p_fs_q  <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            fs_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
            if (h_q == '0 && v_q == VA) begin
                grid_q <= display_array;
                go_q   <= gameover;
            end
            p_h_q   <= h_q;
            p_v_q   <= v_q;
            p_act_q <= h_q < HA && v_q < VA;
            p_hs_q  <= !(h_q >= HS0 && h_q < HS1);
            p_vs_q  <= !(v_q >= VS0 && v_q < VS1);
            p_fs_q  <= h_q == '0 && v_q == '0;
            hs_q    <= p_hs_q;
            vs_q    <= p_vs_q;
            fs_q    <= p_fs_q;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync = hs_q;
    assign vsync = vs_q;
    assign frame_start = fs_q;
    assign red = rgb_q[11:8];
    assign green = rgb_q[7:4];
    assign blue = rgb_q[3:0];
endmodule
